// File: rtl/barrel_shift_seq.sv
// Iterative barrel shifter: one log2 mux stage per clock,
// valid/ready request in, valid/ready result out.
module barrel_shift_seq #(
   parameter int WIDTH = 8,
   parameter int SHW   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_amt,
   input  logic             in_dir,
   input  logic             in_rot,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [SHW-1:0] LAST = SHW'(SHW - 1);

   state_t           state, state_nxt;
   logic [SHW-1:0]   stage;
   logic [WIDTH-1:0] work;
   logic [SHW-1:0]   amt;
   logic             dir;
   logic             rot;

   logic             accept;
   logic             last;
   logic [SHW-1:0]   sh;
   logic [SHW:0]     inv;
   logic [WIDTH-1:0] lsh, rsh, lwrap, rwrap;
   logic [WIDTH-1:0] shifted, stage_out;

   assign accept = (state == IDLE) && in_valid;
   assign last   = (stage == LAST);

   // amt is consumed LSB-first, so bit 0 is always the current stage's select
   assign sh    = SHW'(1) << stage;
   assign inv   = (SHW+1)'(WIDTH) - {1'b0, sh};
   assign lsh   = work << sh;
   assign rsh   = work >> sh;
   assign lwrap = work >> inv;
   assign rwrap = work << inv;

   always_comb begin
      shifted = '0;
      if (dir) shifted = rot ? (rsh | rwrap) : rsh;
      else     shifted = rot ? (lsh | lwrap) : lsh;
   end

   assign stage_out = amt[0] ? shifted : work;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage    <= '0;
         work     <= '0;
         amt      <= '0;
         dir      <= 1'b0;
         rot      <= 1'b0;
         out_data <= '0;
      end else if (accept) begin
         stage <= '0;
         work  <= in_data;
         amt   <= in_amt;
         dir   <= in_dir;
         rot   <= in_rot;
      end else if (state == SHIFT) begin
         work  <= stage_out;
         amt   <= amt >> 1;
         stage <= last ? '0 : stage + SHW'(1);
         if (last) out_data <= stage_out;
      end
   end

endmodule

// File: tb/tb_barrel_shift_seq.sv
// Directed bench for barrel_shift_seq with hand-computed vectors.
module tb_barrel_shift_seq;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [2:0] in_amt;
   logic       in_dir;
   logic       in_rot;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       busy;

   int errors = 0;
   int checks = 0;

   barrel_shift_seq #(.WIDTH(8), .SHW(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_dir    (in_dir),
      .in_rot    (in_rot),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // drive a request and step past its accept edge, then scramble inputs
   task automatic issue(input logic [7:0] d, input logic [2:0] a,
                        input logic dr, input logic rt, input string tag);
      in_valid = 1'b1;
      in_data  = d;
      in_amt   = a;
      in_dir   = dr;
      in_rot   = rt;
      chk({tag, "_in_ready"}, in_ready, 1);
      tick();
      in_valid = 1'b0;
      in_data  = ~d;
      in_amt   = ~a;
      in_dir   = ~dr;
      in_rot   = ~rt;
      chk({tag, "_busy"}, busy, 1);
   endtask

   task automatic wait_result(input logic [7:0] exp, input string tag);
      int cyc = 0;
      while (!out_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      chk({tag, "_lat"}, cyc, 3);
      chk({tag, "_data"}, out_data, exp);
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_ov_low"}, out_valid, 0);
      chk({tag, "_idle_rdy"}, in_ready, 1);
   endtask

   task automatic run_op(input logic [7:0] d, input logic [2:0] a,
                         input logic dr, input logic rt,
                         input logic [7:0] exp, input string tag);
      issue(d, a, dr, rt, tag);
      wait_result(exp, tag);
      drain(tag);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_amt    = '0;
      in_dir    = 1'b0;
      in_rot    = 1'b0;
      out_ready = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("rst_ov",   out_valid, 0);
      chk("rst_data", out_data,  0);
      chk("rst_busy", busy,      0);
      chk("rst_rdy",  in_ready,  1);

      run_op(8'hB1, 3'd3, 1'b0, 1'b0, 8'h88, "lsl3");
      run_op(8'hA5, 3'd1, 1'b1, 1'b1, 8'hD2, "ror1");
      run_op(8'h80, 3'd7, 1'b1, 1'b0, 8'h01, "lsr7");
      run_op(8'h3C, 3'd0, 1'b0, 1'b0, 8'h3C, "amt0");
      run_op(8'h81, 3'd5, 1'b0, 1'b1, 8'h30, "rol5");
      run_op(8'hFF, 3'd6, 1'b1, 1'b0, 8'h03, "lsr6");

      // backpressure: result held, new request stalled
      issue(8'hB1, 3'd3, 1'b0, 1'b0, "bp");
      wait_result(8'h88, "bp");
      in_valid = 1'b1;
      in_data  = 8'h01;
      in_amt   = 3'd2;
      in_dir   = 1'b0;
      in_rot   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold", out_data, 8'h88);
         chk("bp_ov", out_valid, 1);
         chk("bp_rdy", in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_ov_low", out_valid, 0);
      chk("bp_rdy_back", in_ready, 1);
      chk("bp_not_taken", busy, 0);
      tick();
      in_valid = 1'b0;
      chk("bp_accept", busy, 1);
      wait_result(8'h04, "bp2");
      drain("bp2");

      // reset during stage 1 drops the transaction
      issue(8'h55, 3'd7, 1'b0, 1'b1, "mid");
      tick();
      rst_n = 1'b0;
      #1;
      chk("mid_ov",   out_valid, 0);
      chk("mid_data", out_data,  0);
      chk("mid_busy", busy,      0);
      chk("mid_rdy",  in_ready,  1);
      tick();
      rst_n = 1'b1;
      begin
         int seen = 0;
         for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) seen++;
         end
         chk("mid_no_out", seen, 0);
      end
      run_op(8'h0F, 3'd4, 1'b0, 1'b0, 8'hF0, "post");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
